// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 ROM read master.
// The optional opcode prefetch buffer is enabled by defining CHIP8_PREFETCH_EN.
package chip8_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int LEN_W_DEF  = 4;

   localparam logic [11:0] FONT_BASE = 12'h000;
   localparam logic [11:0] PROG_BASE = 12'h200;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      OP_HI    = 4'd1,
      OP_LO    = 4'd2,
      OP_WAIT  = 4'd3,
      BR_ISSUE = 4'd4,
      BR_DRAIN = 4'd5,
      PF_HI    = 4'd6,
      PF_LO    = 4'd7,
      PF_WAIT  = 4'd8
   } state_t;

endpackage

// File: rtl/chip8_mem_reader_if.sv
// Core-side request/response bundle of the CHIP-8 ROM read master.
// master = core (drives requests), slave = reader (drives grants and data).
interface chip8_mem_reader_if #(
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 4
);
   logic              op_req;
   logic [ADDR_W-1:0] op_pc;
   logic              op_gnt;
   logic              op_valid;
   logic [15:0]       op_data;

   logic              br_req;
   logic [ADDR_W-1:0] br_addr;
   logic [LEN_W-1:0]  br_len;
   logic              br_gnt;
   logic              br_valid;
   logic [7:0]        br_data;
   logic              br_last;

   logic              busy;

   modport master (
      output op_req, op_pc, br_req, br_addr, br_len,
      input  op_gnt, op_valid, op_data, br_gnt, br_valid, br_data, br_last, busy
   );

   modport slave (
      input  op_req, op_pc, br_req, br_addr, br_len,
      output op_gnt, op_valid, op_data, br_gnt, br_valid, br_data, br_last, busy
   );
endinterface

// File: rtl/chip8_burst_seq.sv
// Burst sequencer: steps the ROM address once per cycle for the requested
// byte count, then delays the issue strobe two cycles to line up with the
// registered ROM data (one cycle ROM latency + one output register).
module chip8_burst_seq
   import chip8_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [7:0]        i_rdata,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_issue_last,
   output logic              o_valid,
   output logic [7:0]        o_data,
   output logic              o_last
);

   logic              r_active;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_cnt;
   logic              r_s1;
   logic              r_s1_last;
   logic              r_valid;
   logic [7:0]        r_data;
   logic              r_last;
   logic              w_issue_last;

   // remaining count is length-1, so len 0 wraps to 2**LEN_W-1 (a full 16-byte burst)
   assign w_issue_last = r_active && (r_cnt == '0);

   // address stepper and remaining-byte down-counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= 1'b0;
         r_addr   <= '0;
         r_cnt    <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_addr   <= i_addr;
         r_cnt    <= i_len - LEN_W'(1);
      end else if (r_active) begin
         r_addr <= r_addr + ADDR_W'(1);
         r_cnt  <= r_cnt - LEN_W'(1);
         if (w_issue_last) begin
            r_active <= 1'b0;
         end
      end
   end

   // two-stage valid/last pipeline with the byte registered from the ROM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1      <= 1'b0;
         r_s1_last <= 1'b0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_data    <= '0;
      end else begin
         r_s1      <= r_active;
         r_s1_last <= w_issue_last;
         r_valid   <= r_s1;
         r_last    <= r_s1_last;
         if (r_s1) begin
            r_data <= i_rdata;
         end
      end
   end

   assign o_addr       = r_addr;
   assign o_issue_last = w_issue_last;
   assign o_valid      = r_valid;
   assign o_data       = r_data;
   assign o_last       = r_last;

endmodule

// File: rtl/chip8_mem_reader.sv
// CHIP-8 ROM read master: arbitrates opcode fetches against byte bursts and
// owns the ROM address bus. Optional prefetch buffer under CHIP8_PREFETCH_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no transaction, grants possible
// OP_HI    | presenting pc
// OP_LO    | presenting pc+1, high byte returning
// OP_WAIT  | low byte returning, op_valid set on exit
// BR_ISSUE | burst addresses being stepped out
// BR_DRAIN | last burst byte in the ROM/output pipeline
// PF_HI    | prefetch presenting pc+2 (grants still accepted)
// PF_LO    | prefetch presenting pc+3, high byte returning
// PF_WAIT  | prefetch low byte returning, buffer filled on exit
module chip8_mem_reader
   import chip8_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [7:0]        i_mem_rdata,
   chip8_mem_reader_if.slave bus
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic              r_op_valid;
   logic [15:0]       r_op_data;
   logic              r_busy;

   logic              w_accept;
   logic              w_op_gnt;
   logic              w_br_gnt;
   logic [ADDR_W-1:0] w_seq_addr;
   logic              w_seq_last;
   logic              w_br_valid;
   logic [7:0]        w_br_data;
   logic              w_br_last;

`ifdef CHIP8_PREFETCH_EN
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pf_tag;
   logic [15:0]       r_pf_word;
   logic              r_pf_vld;
   logic              r_pf_pend;
   logic              w_pf_hit;

   // a running prefetch never blocks the core, so its states accept grants
   assign w_accept = (r_state == IDLE) || (r_state == PF_HI) ||
                     (r_state == PF_LO) || (r_state == PF_WAIT);
   assign w_pf_hit = r_pf_vld && (bus.op_pc == r_pf_tag);
`else
   assign w_accept = (r_state == IDLE);
`endif

   // grants are gated by rst_n so nothing is accepted while reset is held
   assign w_op_gnt = rst_n & w_accept & bus.op_req;
   assign w_br_gnt = rst_n & w_accept & bus.br_req & ~bus.op_req;

   chip8_burst_seq #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_burst_seq (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_start      (w_br_gnt),
      .i_addr       (bus.br_addr),
      .i_len        (bus.br_len),
      .i_rdata      (i_mem_rdata),
      .o_addr       (w_seq_addr),
      .o_issue_last (w_seq_last),
      .o_valid      (w_br_valid),
      .o_data       (w_br_data),
      .o_last       (w_br_last)
   );

   // arbiter, opcode FSM and prefetch buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_op_valid <= 1'b0;
         r_op_data  <= '0;
         r_busy     <= 1'b0;
`ifdef CHIP8_PREFETCH_EN
         r_pc       <= '0;
         r_pf_tag   <= '0;
         r_pf_word  <= '0;
         r_pf_vld   <= 1'b0;
         r_pf_pend  <= 1'b0;
`endif
      end else begin
         r_op_valid <= 1'b0;
         if (w_op_gnt) begin
`ifdef CHIP8_PREFETCH_EN
            r_pf_pend <= 1'b0;
            r_pc      <= bus.op_pc;
            if (w_pf_hit) begin
               r_op_valid <= 1'b1;
               r_op_data  <= r_pf_word;
               r_pf_vld   <= 1'b0;
               r_addr     <= bus.op_pc + ADDR_W'(2);
               r_state    <= PF_HI;
            end else begin
               r_addr  <= bus.op_pc;
               r_busy  <= 1'b1;
               r_state <= OP_HI;
            end
`else
            r_addr  <= bus.op_pc;
            r_busy  <= 1'b1;
            r_state <= OP_HI;
`endif
         end else if (w_br_gnt) begin
`ifdef CHIP8_PREFETCH_EN
            r_pf_pend <= 1'b0;
            r_pf_vld  <= 1'b0;
`endif
            r_busy  <= 1'b1;
            r_state <= BR_ISSUE;
         end else begin
            case (r_state)
               IDLE: begin
`ifdef CHIP8_PREFETCH_EN
                  if (r_pf_pend) begin
                     r_pf_pend <= 1'b0;
                     r_pf_vld  <= 1'b0;
                     r_addr    <= r_pc + ADDR_W'(2);
                     r_state   <= PF_HI;
                  end
`endif
               end
               OP_HI: begin
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_state <= OP_LO;
               end
               OP_LO: begin
                  r_op_data[15:8] <= i_mem_rdata;
                  r_state         <= OP_WAIT;
               end
               OP_WAIT: begin
                  r_op_data[7:0] <= i_mem_rdata;
                  r_op_valid     <= 1'b1;
                  r_busy         <= 1'b0;
                  r_state        <= IDLE;
`ifdef CHIP8_PREFETCH_EN
                  r_pf_pend      <= 1'b1;
`endif
               end
               BR_ISSUE: begin
                  if (w_seq_last) begin
                     r_state <= BR_DRAIN;
                  end
               end
               BR_DRAIN: begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
`ifdef CHIP8_PREFETCH_EN
               PF_HI: begin
                  r_addr  <= r_addr + ADDR_W'(1);
                  r_state <= PF_LO;
               end
               PF_LO: begin
                  r_pf_word[15:8] <= i_mem_rdata;
                  r_state         <= PF_WAIT;
               end
               PF_WAIT: begin
                  r_pf_word[7:0] <= i_mem_rdata;
                  r_pf_tag       <= r_pc + ADDR_W'(2);
                  r_pf_vld       <= 1'b1;
                  r_state        <= IDLE;
               end
`endif
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   // the burst sequencer drives the ROM only while its addresses are going out
   assign o_mem_addr   = (r_state == BR_ISSUE) ? w_seq_addr : r_addr;

   assign bus.op_gnt   = w_op_gnt;
   assign bus.op_valid = r_op_valid;
   assign bus.op_data  = r_op_data;
   assign bus.br_gnt   = w_br_gnt;
   assign bus.br_valid = w_br_valid;
   assign bus.br_data  = w_br_data;
   assign bus.br_last  = w_br_last;
   assign bus.busy     = r_busy;

endmodule
